// File: rtl/ysq_seq.sv
// YSQ sequencer: decodes one arithmetic instruction (or multiply-add request) into YSQ selects and load strobes.
// Optional multiply-add path compiled in with `define YSQ_SEQ_MAC_EN.
module ysq_seq #(
  parameter int unsigned DD_TMO = 64
) (
  input  logic        clk_mdv,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  input  logic        i_mac,
  input  logic [15:0] i_MX,
  input  logic        i_YIC,
  input  logic        i_DD,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_skip,
  output logic        o_err,
  output logic [3:0]  o_L_Mcs,
  output logic [3:0]  o_Ln_Mjg,
  output logic        o_Mcs_Q,
  output logic        o_Mcsn_Q,
  output logic        o_Mjg_Q,
  output logic        o_McsMjg_Q,
  output logic        o_1_Q,
  output logic        o_JW0,
  output logic        o_JWF,
  output logic        o_Q_MX,
  output logic        o_Q_Y_MX,
  output logic        o_Q_Z_MX,
  output logic        o_Q_B_MX,
  output logic        o_DRJG,
  output logic [3:0]  o_DRL,
  output logic        o_DRCj,
  output logic        o_DRCCQ,
  output logic        o_CHJ,
  output logic        o_CCQ
);

  localparam int unsigned AC_N   = 4;
  localparam int unsigned FIELD_W = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_STB,
    S_WB,
    S_FIN,
    S_REQ,
    S_WAIT,
    S_MWB,
    S_HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [FIELD_W-1:0] ir_q;
  logic               err_q;
  logic               skip_q;

  logic [1:0] acs;
  logic [1:0] acd;
  logic [2:0] func;
  logic [1:0] shift;
  logic [1:0] carry;
  logic       noload;
  logic [2:0] skip_sel;

  logic illegal_c;
  logic skip_c;
  logic dd_tmo_c;

  // decoded select levels, valid whenever an arithmetic op is latched
  logic [AC_N-1:0] dec_l_mcs;
  logic [AC_N-1:0] dec_ln_mjg;
  logic [AC_N-1:0] dec_drl;
  logic dec_mcs, dec_mcsn, dec_mjg, dec_mcsmjg, dec_one;
  logic dec_jw0, dec_jwf;
  logic dec_q_mx, dec_q_y_mx, dec_q_z_mx, dec_q_b_mx;

  // next values of the registered outputs
  logic            busy_d, done_d, skip_d, err_d;
  logic [AC_N-1:0] l_mcs_d, ln_mjg_d, drl_d;
  logic            mcs_d, mcsn_d, mjg_d, mcsmjg_d, one_d;
  logic            jw0_d, jwf_d;
  logic            q_mx_d, q_y_mx_d, q_z_mx_d, q_b_mx_d;
  logic            drjg_d, drcj_d, drccq_d, chj_d, ccq_d;

  assign acs      = ir_q[14:13];
  assign acd      = ir_q[12:11];
  assign func     = ir_q[10:8];
  assign shift    = ir_q[7:6];
  assign carry    = ir_q[5:4];
  assign noload   = ir_q[3];
  assign skip_sel = ir_q[2:0];

`ifdef YSQ_SEQ_MAC_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;

  assign illegal_c = !i_mac && !i_ir[15];
  assign dd_tmo_c  = (cnt_q == CNT_W'(DD_TMO - 1));

  // counts WAIT cycles spent with the storage unit still busy
  always_ff @(posedge clk_mdv) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic [8:0] unused_cfg;

  assign illegal_c  = i_mac || !i_ir[15];
  assign dd_tmo_c   = 1'b0;
  assign unused_cfg = {i_DD, 8'(DD_TMO)};
`endif

  // skip condition from the YSQ result as it stands during write-back
  always_comb begin
    logic z;
    z      = (i_MX == 16'h0000);
    skip_c = 1'b0;
    case (skip_sel)
      3'd0: skip_c = 1'b0;
      3'd1: skip_c = 1'b1;
      3'd2: skip_c = !i_YIC;
      3'd3: skip_c = i_YIC;
      3'd4: skip_c = z;
      3'd5: skip_c = !z;
      3'd6: skip_c = !i_YIC || z;
      3'd7: skip_c = i_YIC && !z;
      default: skip_c = 1'b0;
    endcase
  end

  always_comb begin
    dec_l_mcs  = AC_N'(1) << acs;
    dec_ln_mjg = AC_N'(1) << acd;
    dec_drl    = AC_N'(1) << acd;
    dec_mcs    = 1'b0;
    dec_mcsn   = 1'b0;
    dec_mjg    = 1'b0;
    dec_mcsmjg = 1'b0;
    dec_one    = 1'b0;
    case (func)
      3'd0: dec_mcsn = 1'b1;
      3'd1: begin dec_mcsn = 1'b1; dec_one = 1'b1; end
      3'd2: dec_mcs = 1'b1;
      3'd3: begin dec_mcs = 1'b1; dec_one = 1'b1; end
      3'd4: begin dec_mcsn = 1'b1; dec_mjg = 1'b1; end
      3'd5: begin dec_mcsn = 1'b1; dec_mjg = 1'b1; dec_one = 1'b1; end
      3'd6: begin dec_mcs = 1'b1; dec_mjg = 1'b1; end
      3'd7: dec_mcsmjg = 1'b1;
      default: dec_mcs = 1'b0;
    endcase
    dec_jw0    = (carry == 2'd1) || (carry == 2'd2);
    dec_jwf    = (carry == 2'd2) || (carry == 2'd3);
    dec_q_mx   = (shift == 2'd0);
    dec_q_y_mx = (shift == 2'd1);
    dec_q_z_mx = (shift == 2'd2);
    dec_q_b_mx = (shift == 2'd3);
  end

  // instruction latch, completion status
  always_ff @(posedge clk_mdv) begin
    if (rst) begin
      ir_q   <= '0;
      err_q  <= 1'b0;
      skip_q <= 1'b0;
    end else if (state_q == S_IDLE && i_start) begin
      ir_q   <= i_ir[FIELD_W-1:0];
      err_q  <= illegal_c;
      skip_q <= 1'b0;
    end else if (state_q == S_WB) begin
      skip_q <= skip_c;
    end else if (state_q == S_WAIT && i_DD && dd_tmo_c) begin
      err_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_mdv) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (illegal_c) begin
            state_d = S_FIN;
`ifdef YSQ_SEQ_MAC_EN
          end else if (i_mac) begin
            state_d = S_REQ;
`endif
          end else begin
            state_d = S_SEL;
          end
        end
      end
      S_SEL: state_d = S_STB;
      S_STB: state_d = S_WB;
      S_WB:  state_d = S_FIN;
      S_FIN: state_d = S_IDLE;
`ifdef YSQ_SEQ_MAC_EN
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (!i_DD) begin
          state_d = S_MWB;
        end else if (dd_tmo_c) begin
          state_d = S_FIN;
        end
      end
      S_MWB:  state_d = S_HOLD;
      S_HOLD: state_d = S_FIN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // outputs lag the state by one edge so every level and strobe leaves a flop
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    skip_d   = 1'b0;
    err_d    = 1'b0;
    l_mcs_d  = '0;
    ln_mjg_d = '0;
    drl_d    = '0;
    mcs_d    = 1'b0;
    mcsn_d   = 1'b0;
    mjg_d    = 1'b0;
    mcsmjg_d = 1'b0;
    one_d    = 1'b0;
    jw0_d    = 1'b0;
    jwf_d    = 1'b0;
    q_mx_d   = 1'b0;
    q_y_mx_d = 1'b0;
    q_z_mx_d = 1'b0;
    q_b_mx_d = 1'b0;
    drjg_d   = 1'b0;
    drcj_d   = 1'b0;
    drccq_d  = 1'b0;
    chj_d    = 1'b0;
    ccq_d    = 1'b0;
    case (state_q)
      S_SEL, S_STB, S_WB: begin
        l_mcs_d  = dec_l_mcs;
        ln_mjg_d = dec_ln_mjg;
        mcs_d    = dec_mcs;
        mcsn_d   = dec_mcsn;
        mjg_d    = dec_mjg;
        mcsmjg_d = dec_mcsmjg;
        one_d    = dec_one;
        jw0_d    = dec_jw0;
        jwf_d    = dec_jwf;
        q_mx_d   = dec_q_mx;
        q_y_mx_d = dec_q_y_mx;
        q_z_mx_d = dec_q_z_mx;
        q_b_mx_d = dec_q_b_mx;
        drjg_d   = (state_q == S_STB);
        if (state_q == S_WB && !noload) begin
          drl_d  = dec_drl;
          drcj_d = 1'b1;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        skip_d = skip_q;
        err_d  = err_q;
      end
`ifdef YSQ_SEQ_MAC_EN
      S_REQ: begin
        chj_d   = 1'b1;
        drccq_d = 1'b1;
      end
      S_WAIT: chj_d = 1'b1;
      S_MWB: begin
        ccq_d  = 1'b1;
        drl_d  = 4'b0011;
        drcj_d = 1'b1;
      end
      S_HOLD: ccq_d = 1'b1;
`endif
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_mdv) begin
    if (rst) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_skip     <= 1'b0;
      o_err      <= 1'b0;
      o_L_Mcs    <= '0;
      o_Ln_Mjg   <= '0;
      o_Mcs_Q    <= 1'b0;
      o_Mcsn_Q   <= 1'b0;
      o_Mjg_Q    <= 1'b0;
      o_McsMjg_Q <= 1'b0;
      o_1_Q      <= 1'b0;
      o_JW0      <= 1'b0;
      o_JWF      <= 1'b0;
      o_Q_MX     <= 1'b0;
      o_Q_Y_MX   <= 1'b0;
      o_Q_Z_MX   <= 1'b0;
      o_Q_B_MX   <= 1'b0;
      o_DRJG     <= 1'b0;
      o_DRL      <= '0;
      o_DRCj     <= 1'b0;
      o_DRCCQ    <= 1'b0;
      o_CHJ      <= 1'b0;
      o_CCQ      <= 1'b0;
    end else begin
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_skip     <= skip_d;
      o_err      <= err_d;
      o_L_Mcs    <= l_mcs_d;
      o_Ln_Mjg   <= ln_mjg_d;
      o_Mcs_Q    <= mcs_d;
      o_Mcsn_Q   <= mcsn_d;
      o_Mjg_Q    <= mjg_d;
      o_McsMjg_Q <= mcsmjg_d;
      o_1_Q      <= one_d;
      o_JW0      <= jw0_d;
      o_JWF      <= jwf_d;
      o_Q_MX     <= q_mx_d;
      o_Q_Y_MX   <= q_y_mx_d;
      o_Q_Z_MX   <= q_z_mx_d;
      o_Q_B_MX   <= q_b_mx_d;
      o_DRJG     <= drjg_d;
      o_DRL      <= drl_d;
      o_DRCj     <= drcj_d;
      o_DRCCQ    <= drccq_d;
      o_CHJ      <= chj_d;
      o_CCQ      <= ccq_d;
    end
  end

endmodule

// File: tb/tb_ysq_seq.sv
// Self-checking bench for ysq_seq: directed and random ops against a per-edge expected output picture.
module tb_ysq_seq;

  localparam int unsigned TMO = 64;

  logic        clk_mdv;
  logic        rst;
  logic        i_start;
  logic [15:0] i_ir;
  logic        i_mac;
  logic [15:0] i_MX;
  logic        i_YIC;
  logic        i_DD;
  logic        o_busy, o_done, o_skip, o_err;
  logic [3:0]  o_L_Mcs, o_Ln_Mjg, o_DRL;
  logic        o_Mcs_Q, o_Mcsn_Q, o_Mjg_Q, o_McsMjg_Q, o_1_Q;
  logic        o_JW0, o_JWF, o_Q_MX, o_Q_Y_MX, o_Q_Z_MX, o_Q_B_MX;
  logic        o_DRJG, o_DRCj, o_DRCCQ, o_CHJ, o_CCQ;

  int checks;
  int failures;

  typedef struct packed {
    logic       busy, done, skip, err;
    logic [3:0] l_mcs, ln_mjg;
    logic       mcs, mcsn, mjg, mcsmjg, one;
    logic       jw0, jwf, q_mx, q_y_mx, q_z_mx, q_b_mx, drjg;
    logic [3:0] drl;
    logic       drcj, drccq, chj, ccq;
  } obs_t;

  obs_t obs;
  assign obs = {o_busy, o_done, o_skip, o_err, o_L_Mcs, o_Ln_Mjg,
                o_Mcs_Q, o_Mcsn_Q, o_Mjg_Q, o_McsMjg_Q, o_1_Q,
                o_JW0, o_JWF, o_Q_MX, o_Q_Y_MX, o_Q_Z_MX, o_Q_B_MX, o_DRJG,
                o_DRL, o_DRCj, o_DRCCQ, o_CHJ, o_CCQ};

  ysq_seq #(.DD_TMO(TMO)) dut (
    .clk_mdv(clk_mdv), .rst(rst), .i_start(i_start), .i_ir(i_ir), .i_mac(i_mac),
    .i_MX(i_MX), .i_YIC(i_YIC), .i_DD(i_DD),
    .o_busy(o_busy), .o_done(o_done), .o_skip(o_skip), .o_err(o_err),
    .o_L_Mcs(o_L_Mcs), .o_Ln_Mjg(o_Ln_Mjg),
    .o_Mcs_Q(o_Mcs_Q), .o_Mcsn_Q(o_Mcsn_Q), .o_Mjg_Q(o_Mjg_Q), .o_McsMjg_Q(o_McsMjg_Q), .o_1_Q(o_1_Q),
    .o_JW0(o_JW0), .o_JWF(o_JWF),
    .o_Q_MX(o_Q_MX), .o_Q_Y_MX(o_Q_Y_MX), .o_Q_Z_MX(o_Q_Z_MX), .o_Q_B_MX(o_Q_B_MX),
    .o_DRJG(o_DRJG), .o_DRL(o_DRL), .o_DRCj(o_DRCj),
    .o_DRCCQ(o_DRCCQ), .o_CHJ(o_CHJ), .o_CCQ(o_CCQ)
  );

  initial begin
    clk_mdv = 1'b0;
    forever #5 clk_mdv = ~clk_mdv;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Select levels an arithmetic instruction should present to the YSQ.
  function automatic obs_t exp_sel(input logic [15:0] ir);
    obs_t s;
    s = '0;
    s.l_mcs  = 4'b0001 << ir[14:13];
    s.ln_mjg = 4'b0001 << ir[12:11];
    case (ir[10:8])
      3'd0: s.mcsn = 1'b1;
      3'd1: begin s.mcsn = 1'b1; s.one = 1'b1; end
      3'd2: s.mcs = 1'b1;
      3'd3: begin s.mcs = 1'b1; s.one = 1'b1; end
      3'd4: begin s.mcsn = 1'b1; s.mjg = 1'b1; end
      3'd5: begin s.mcsn = 1'b1; s.mjg = 1'b1; s.one = 1'b1; end
      3'd6: begin s.mcs = 1'b1; s.mjg = 1'b1; end
      default: s.mcsmjg = 1'b1;
    endcase
    case (ir[5:4])
      2'd0: ;
      2'd1: s.jw0 = 1'b1;
      2'd2: begin s.jw0 = 1'b1; s.jwf = 1'b1; end
      default: s.jwf = 1'b1;
    endcase
    case (ir[7:6])
      2'd0: s.q_mx = 1'b1;
      2'd1: s.q_y_mx = 1'b1;
      2'd2: s.q_z_mx = 1'b1;
      default: s.q_b_mx = 1'b1;
    endcase
    return s;
  endfunction

  function automatic logic exp_skip(input logic [2:0] cond, input logic [15:0] mx, input logic c);
    logic z;
    z = (mx == 16'h0000);
    case (cond)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return !c;
      3'd3: return c;
      3'd4: return z;
      3'd5: return !z;
      3'd6: return !c || z;
      default: return c && !z;
    endcase
  endfunction

  // One instruction from E0 through one idle edge after completion; poke re-asserts i_start while busy.
  task automatic run_arith(input logic [15:0] ir, input logic [15:0] mx, input logic yic,
                           input bit poke, input string name);
    obs_t sel, e;
    logic legal;
    legal = ir[15];
    sel   = exp_sel(ir);
    i_ir = ir; i_mac = 1'b0; i_start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk_mdv); #1;
      i_start = poke && legal && (k <= 3);
      i_MX    = (k == 2) ? mx  : 16'($urandom);
      i_YIC   = (k == 2) ? yic : 1'($urandom);
      e = '0;
      if (legal) begin
        if (k >= 1 && k <= 3) e = sel;
        if (k <= 3) e.busy = 1'b1;
        if (k == 2) e.drjg = 1'b1;
        if (k == 3 && !ir[3]) begin
          e.drl  = 4'b0001 << ir[12:11];
          e.drcj = 1'b1;
        end
        if (k == 4) begin
          e.done = 1'b1;
          e.skip = exp_skip(ir[2:0], mx, yic);
        end
      end else begin
        if (k == 0) e.busy = 1'b1;
        if (k == 1) begin e.done = 1'b1; e.err = 1'b1; end
      end
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s ir=%h edge=%0d got=%h want=%h", name, ir, k, obs, e);
      end
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_mdv); #1;
      checks++;
      if (obs !== obs_t'('0)) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h want=0", k, obs);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_arith(16'hB600, 16'($urandom), 1'($urandom), 1'b0, "add_ac1_ac2");
  endtask

  task automatic test_sub_szr();
    run_arith(16'h8504, 16'h0000, 1'b0, 1'b0, "sub_szr_zero");
    run_arith(16'h8504, 16'h0001, 1'b1, 1'b0, "sub_szr_nonzero");
  endtask

  task automatic test_mov_swap_noload();
    run_arith(16'h8AC8, 16'($urandom), 1'($urandom), 1'b0, "mov_swap_noload");
  endtask

  task automatic test_illegal();
    run_arith(16'h7FFF, 16'h0000, 1'b1, 1'b0, "non_arith");
    run_arith(16'h0001, 16'h0000, 1'b1, 1'b0, "non_arith_skip");
  endtask

  task automatic test_back_to_back();
    run_arith(16'hB600, 16'h0000, 1'b0, 1'b1, "start_while_busy");
    run_arith(16'h9E07, 16'h1234, 1'b1, 1'b1, "start_while_busy2");
  endtask

  task automatic test_reset_mid_op();
    obs_t e;
    i_ir = 16'hB600; i_mac = 1'b0; i_start = 1'b1;
    @(posedge clk_mdv); #1;
    i_start = 1'b0;
    @(posedge clk_mdv); #1;
    e = exp_sel(16'hB600);
    e.busy = 1'b1;
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL rst_mid_sel got=%h want=%h", obs, e);
    end
    rst = 1'b1;
    @(posedge clk_mdv); #1;
    rst = 1'b0;
    checks++;
    if (obs !== obs_t'('0)) begin
      failures++;
      $display("FAIL rst_mid_clear got=%h want=0", obs);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_mdv); #1;
      checks++;
      if (obs !== obs_t'('0)) begin
        failures++;
        $display("FAIL rst_mid_after cyc=%0d got=%h want=0", k, obs);
      end
    end
  endtask

`ifdef YSQ_SEQ_MAC_EN
  // n = number of consecutive busy cycles the storage unit reports once WAIT is entered
  task automatic run_mac(input int n, input string name);
    obs_t e;
    int   we;
    int   last;
    bit   tmo;
    tmo  = (n >= int'(TMO));
    we   = tmo ? int'(TMO) : n + 1;
    last = tmo ? 2 + we : 4 + we;
    i_mac = 1'b1; i_ir = 16'($urandom); i_start = 1'b1; i_DD = 1'($urandom);
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk_mdv); #1;
      i_start = 1'b0;
      if (k >= 1) i_DD = (k - 1 < n);
      e = '0;
      if (k < last) e.busy = 1'b1;
      if (k == 1) e.drccq = 1'b1;
      if (k >= 1 && k <= 1 + we) e.chj = 1'b1;
      if (!tmo && k == 2 + we) begin
        e.ccq = 1'b1; e.drl = 4'b0011; e.drcj = 1'b1;
      end
      if (!tmo && k == 3 + we) e.ccq = 1'b1;
      if (k == last) begin
        e.done = 1'b1;
        e.err  = tmo;
      end
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s n=%0d edge=%0d got=%h want=%h", name, n, k, obs, e);
      end
    end
    i_mac = 1'b0; i_DD = 1'b0;
  endtask

  task automatic test_mac();
    run_mac(5, "mac_dd5");
    run_mac(0, "mac_dd0");
    run_mac(int'(TMO) - 1, "mac_dd_edge");
    run_mac(int'(TMO), "mac_timeout");
    run_mac(int'(TMO) + 20, "mac_timeout_long");
  endtask
`else
  task automatic test_mac();
    obs_t e;
    i_mac = 1'b1; i_ir = 16'hB600; i_start = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk_mdv); #1;
      i_start = 1'b0;
      i_DD = 1'($urandom);
      e = '0;
      if (k == 0) e.busy = 1'b1;
      if (k == 1) begin e.done = 1'b1; e.err = 1'b1; end
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mac_disabled edge=%0d got=%h want=%h", k, obs, e);
      end
    end
    i_mac = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [15:0] ir, mx;
    for (int t = 0; t < 40; t++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ir[15] = 1'b1;
      mx = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_arith(ir, mx, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    i_start = 1'b0; i_ir = '0; i_mac = 1'b0; i_MX = '0; i_YIC = 1'b0; i_DD = 1'b0;
    rst = 1'b1;
    test_reset();
    test_add();
    test_sub_szr();
    test_mov_swap_noload();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_mac();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
